mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 139 +++++++++++++
 tb/tb_mdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Operands and the full result are captured when an operation launches.
// HI/LO commit only when the multi-cycle Busy window ends.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic               is_mul, is_div, launch, done;
  logic               sgn_mul, sgn_div, a_neg, b_neg;
  logic [63:0]        prod;
  logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Operation decode and launch/completion conditions
  always_comb begin
    is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    launch = (state_q == IDLE) && Start && (is_mul || is_div);
    done   = (state_q == BUSY) && (cnt_q <= CNT_W'(1));
  end

  // Result arithmetic: sign-extend for MULT, magnitude divide with sign fix-up for DIV
  always_comb begin
    sgn_mul = (MDUOp == OP_MULT);
    sgn_div = (MDUOp == OP_DIV);
    prod    = {{32{sgn_mul & A[31]}}, A} * {{32{sgn_mul & B[31]}}, B};
    a_neg   = sgn_div & A[31];
    b_neg   = sgn_div & B[31];
    a_mag   = a_neg ? -A : A;
    b_mag   = b_neg ? -B : B;
    // Keep the divider free of X when B==0; that result is discarded anyway.
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    // 0x80000000 / -1 wraps naturally back to 0x80000000 here.
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
  end

  // Next-state logic for the IDLE/BUSY controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on launch, count down, commit on done, MTHI/MTLO in IDLE
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (state_q == IDLE) begin
      if (launch) begin
        if (is_mul) begin
          cnt_d    = CNT_W'(MULT_CYCLES);
          hi_tmp_d = prod[63:32];
          lo_tmp_d = prod[31:0];
        end else begin
          cnt_d = CNT_W'(DIV_CYCLES);
          // Divide by zero commits the current HI/LO, which cannot change while busy.
          if (B == 32'd0) begin
            hi_tmp_d = hi_q;
            lo_tmp_d = lo_q;
          end else begin
            hi_tmp_d = rem;
            lo_tmp_d = quo;
          end
        end
      end
      if (MDUOp == OP_MTHI) hi_d = A;
      if (MDUOp == OP_MTLO) lo_d = A;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (done) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end
  end

  // State and datapath registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    Busy = (state_q == BUSY);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes per-cycle expectations, a monitor
// pops and compares them on the falling edge.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result using plain 64-bit arithmetic
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb_, p, q, r;
    logic [63:0] up;
    rh = m_hi; rl = m_lo;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb_; up = p; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; rh = up[63:32]; rl = up[31:0]; end
      3'd3: if (b != 0) begin
              q = sa / sb_; r = sa % sb_;
              up = q; rl = up[31:0];
              up = r; rh = up[31:0];
            end
      3'd4: if (b != 0) begin rl = a / b; rh = a % b; end
      default: ;
    endcase
  endtask

  task automatic push(input int unsigned due, input bit busy, input string tag);
    exp_t e;
    e.due = due; e.busy = busy; e.hi = m_hi; e.lo = m_lo; e.tag = tag;
    sb.push_back(e);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic issue(input logic [2:0] op, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input bit inj, input string tag);
    int unsigned e;
    int          n;
    logic [31:0] rh, rl;
    Start = st; MDUOp = op; A = a; B = b;
    e = cyc + 1;
    if (st && op >= 3'd1 && op <= 3'd4) begin
      n = (op <= 3'd2) ? MC : DC;
      for (int i = 0; i < n; i++) push(e + i, 1'b1, tag);
      ref_op(op, a, b, rh, rl);
      m_hi = rh; m_lo = rl;
      push(e + n, 1'b0, tag);
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        Start = 1'b0; MDUOp = 3'd0;
        if (inj && i == 1) begin
          Start = 1'b1; MDUOp = 3'd3; A = $urandom; B = 32'd3;
        end else if (inj && i == 2) begin
          MDUOp = 3'd6; A = 32'hDEADBEEF;
        end
      end
    end else begin
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      push(e, 1'b0, tag);
      @(negedge clk);
      Start = 1'b0; MDUOp = 3'd0;
    end
    $display("op=%0d start=%0b A=%08h B=%08h -> exp HI=%08h LO=%08h (%s)",
             op, st, a, b, m_hi, m_lo, tag);
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          total++; bad++;
          $display("FAIL %s missed: due=%0d now=%0d", e.tag, e.due, cyc);
        end else begin
          total += 3;
          if (Busy !== e.busy) begin
            bad++; $display("FAIL %s busy@%0d: got %0b want %0b", e.tag, cyc, Busy, e.busy);
          end
          if (HI !== e.hi) begin
            bad++; $display("FAIL %s HI@%0d: got %08h want %08h", e.tag, cyc, HI, e.hi);
          end
          if (LO !== e.lo) begin
            bad++; $display("FAIL %s LO@%0d: got %08h want %08h", e.tag, cyc, LO, e.lo);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e;
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; Start = 1'b1; MDUOp = 3'd5; A = 32'h12345678; B = 32'd1;
    @(negedge clk);
    m_hi = 0; m_lo = 0;
    push(cyc + 1, 1'b0, "reset");
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDUOp = 3'd0;
    @(negedge clk);

    issue(3'd1, 1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg3x5");
    issue(3'd2, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
    issue(3'd3, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg7by2");
    issue(3'd5, 1'b0, 32'h11111111, 32'd0, 1'b0, "mthi");
    issue(3'd6, 1'b0, 32'h22222222, 32'd0, 1'b0, "mtlo");
    issue(3'd4, 1'b1, 32'h00001234, 32'd0, 1'b0, "divu_by0");
    issue(3'd3, 1'b1, 32'h80000000, 32'd0, 1'b0, "div_by0");
    issue(3'd1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b1, "mult_ignore");
    issue(3'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    issue(3'd5, 1'b1, 32'hABCD0000, 32'd0, 1'b0, "mthi_start");
    issue(3'd0, 1'b1, 32'h1, 32'h1, 1'b0, "none_start");
    issue(3'd7, 1'b1, 32'h1, 32'h1, 1'b0, "rsvd_start");

    // Reset pulsed on busy cycle 4 of a DIV abandons the result
    Start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd7;
    e = cyc + 1;
    for (int i = 0; i < 4; i++) push(e + i, 1'b1, "div_reset");
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    for (int i = 4; i < 4 + DC + 2; i++) push(e + i, 1'b0, "div_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    $display("div reset mid-flight -> exp HI=0 LO=0 Busy=0");

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      issue(op, 1'($urandom_range(0, 3) != 0), a, b, 1'($urandom_range(0, 3) == 0), "rand");
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
